// File: rtl/clkdiv_pkg.sv
// Shared types, constants and divisor helpers for the multi-channel soft clock divider.
package clkdiv_pkg;

    localparam int unsigned CLKDIV_WIDTH = 8;
    localparam int unsigned CALC_W       = 32;

    typedef logic [CLKDIV_WIDTH-1:0] div_t;

    localparam div_t CLKDIV_DEFAULT_DIV = div_t'(5);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } chan_state_t;

    // Divisors 0 and 1 both mean divide-by-one.
    function automatic logic [CALC_W-1:0] eff_div(input logic [CALC_W-1:0] n);
        return (n == '0) ? CALC_W'(1) : n;
    endfunction

    // Number of high cycles per period, ceil(N/2).
    function automatic logic [CALC_W-1:0] half_div(input logic [CALC_W-1:0] n);
        logic [CALC_W-1:0] e;
        e = eff_div(n);
        return (e + CALC_W'(1)) >> 1;
    endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: period counter, pending divisor register and registered clkout/ce.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int unsigned WIDTH       = CLKDIV_WIDTH,
    parameter int unsigned DEFAULT_DIV = 32'(CLKDIV_DEFAULT_DIV)
) (
    input  logic             hclkin,
    input  logic             resetn,
    input  logic             div_load,
    input  logic [WIDTH-1:0] div_value,
    input  logic             calib,
    input  logic             sync,
    output logic             clkout,
    output logic             ce,
    output logic [WIDTH-1:0] div_active
);

    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);

    chan_state_t      state, state_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] div_q, div_n;
    logic             pend_q, pend_n;
    logic [WIDTH-1:0] pval_q, pval_n;
    logic             clk_q, clk_n;
    logic             ce_q, ce_n;

    logic [CALC_W-1:0] n_cur;
    logic              at_end;
    logic              hold;
    logic              restart;

    // cnt is the count shown on the outputs; outputs are computed from the next count.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        div_n   = div_q;
        pend_n  = pend_q | div_load;
        pval_n  = div_load ? div_value : pval_q;
        clk_n   = clk_q;
        ce_n    = 1'b0;

        n_cur   = eff_div(CALC_W'(div_q));
        at_end  = (CALC_W'(cnt) == n_cur - CALC_W'(1));
        hold    = calib && !sync;
        restart = sync || (state == ST_IDLE);

        if (!hold) begin
            if (restart || at_end) begin
                cnt_n   = '0;
                state_n = ST_RUN;
                if (pend_n) begin
                    div_n  = pval_n;
                    pend_n = 1'b0;
                end
            end else begin
                cnt_n = cnt + WIDTH'(1);
            end
            clk_n = (CALC_W'(cnt_n) < half_div(CALC_W'(div_n)));
            ce_n  = (CALC_W'(cnt_n) == eff_div(CALC_W'(div_n)) - CALC_W'(1));
        end
    end

    always_ff @(posedge hclkin) begin
        if (!resetn) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            div_q  <= RST_DIV;
            pend_q <= 1'b0;
            pval_q <= '0;
            clk_q  <= 1'b0;
            ce_q   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            div_q  <= div_n;
            pend_q <= pend_n;
            pval_q <= pval_n;
            clk_q  <= clk_n;
            ce_q   <= ce_n;
        end
    end

    assign clkout     = clk_q;
    assign ce         = ce_q;
    assign div_active = div_q;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider; calib and sync are shared by every channel.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned WIDTH       = CLKDIV_WIDTH,
    parameter int unsigned DEFAULT_DIV = 32'(CLKDIV_DEFAULT_DIV)
) (
    input  logic                      hclkin,
    input  logic                      resetn,
    input  logic [CHANNELS-1:0]       div_load,
    input  logic [CHANNELS*WIDTH-1:0] div_value,
    input  logic                      calib,
    input  logic                      sync,
    output logic [CHANNELS-1:0]       clkout,
    output logic [CHANNELS-1:0]       ce,
    output logic [CHANNELS*WIDTH-1:0] div_active
);

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_chan
        clkdiv_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .hclkin     (hclkin),
            .resetn     (resetn),
            .div_load   (div_load[g]),
            .div_value  (div_value[g*WIDTH +: WIDTH]),
            .calib      (calib),
            .sync       (sync),
            .clkout     (clkout[g]),
            .ce         (ce[g]),
            .div_active (div_active[g*WIDTH +: WIDTH])
        );
    end

endmodule
